// File: rtl/d16_mem_pkg.sv
// Shared definitions for the wait-stated dual-port word memory.
// Holds the port-A FSM encoding, counter sizing and the lane-index width helper.
package d16_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ws_state_t;

    localparam int WAIT_STATES_MAX = 15;
    localparam int CNT_W           = 4;

    // Width of a lane index; a single-lane word still keeps a 1-bit select.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/mem_ws_array.sv
// True dual-port word storage with per-lane port-A write enables.
// Latency: registered read, data one cycle after the read edge; read-before-write on both ports.
// Backpressure: none, both ports accept an operation every cycle.
module mem_ws_array #(
    parameter int  LANES  = 2,
    parameter int  ADDR_W = 14,
    localparam int DATA_W = 8 * LANES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_re,
    input  logic [LANES-1:0]  a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Port-A lane writes come last so they win over port B on a same-word collision.
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
        for (int l = 0; l < LANES; l++) begin
            if (a_we[l]) begin
                mem[a_addr][8*l +: 8] <= a_wdata[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_re) begin
                a_rdata <= mem[a_addr];
            end
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/mem_ws_ctrl.sv
// Wait-stated port-A controller (word/byte access, sign extension) plus unstalled port B.
// Latency: port A ready WAIT_STATES+1 cycles after accept; port B read data next cycle.
// Backpressure: mem_wait stalls the port-A requester; port B never stalls.
module mem_ws_ctrl
    import d16_mem_pkg::*;
#(
    parameter int  LANES       = 2,
    parameter int  DEPTH_LOG2  = 14,
    parameter int  WAIT_STATES = 0,
    localparam int DATA_W      = 8 * LANES,
    localparam int SEL_W       = lane_idx_w(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              write_enable,
    input  logic              byte_enable,
    input  logic [SEL_W-1:0]  byte_select,
    input  logic              sign_ext,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_wait,
    output logic              ready,
    input  logic              write_enable_2,
    input  logic [15:0]       addr2,
    input  logic [DATA_W-1:0] data_in2,
    output logic [DATA_W-1:0] data_out2,
    output logic              collision
);

    localparam logic [CNT_W-1:0]  WS_CNT   = CNT_W'(WAIT_STATES);
    localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'(8'hFF);

    ws_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  accept, fire;

    logic [DEPTH_LOG2-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  we_q, be_q, sx_q;
    logic [SEL_W-1:0]      sel_q;

    logic                  fbyte_q, fsx_q;
    logic [SEL_W-1:0]      fsel_q;

    logic [LANES-1:0]      a_we;
    logic [DATA_W-1:0]     a_wdata, a_rdata;
    logic                  a_re;
    logic [7:0]            lane;

    logic                  unused_addr_hi;
    assign unused_addr_hi = &{1'b0, addr[15:DEPTH_LOG2], addr2[15:DEPTH_LOG2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    accept  = 1'b1;
                    cnt_d   = WS_CNT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    fire    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_wait = (state_q == BUSY) || ((state_q == IDLE) && en);

    // Request is captured once; anything the requester does while BUSY is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            be_q   <= 1'b0;
            sx_q   <= 1'b0;
            sel_q  <= '0;
        end else if (accept) begin
            addr_q <= addr[DEPTH_LOG2-1:0];
            data_q <= data_in;
            we_q   <= write_enable;
            be_q   <= byte_enable;
            sx_q   <= sign_ext;
            sel_q  <= byte_select;
        end
    end

    always_comb begin
        a_we = '0;
        if (fire && we_q) begin
            if (!be_q) begin
                a_we = '1;
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    if (int'(sel_q) == l) a_we[l] = 1'b1;
                end
            end
        end
    end

    assign a_wdata = be_q ? {LANES{data_q[7:0]}} : data_q;
    assign a_re    = fire && !we_q;

    mem_ws_array #(
        .LANES  (LANES),
        .ADDR_W (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .a_re    (a_re),
        .a_we    (a_we),
        .a_addr  (addr_q),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .b_we    (write_enable_2),
        .b_addr  (addr2[DEPTH_LOG2-1:0]),
        .b_wdata (data_in2),
        .b_rdata (data_out2)
    );

    // Format controls are frozen with the read data so data_out holds until the next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready     <= 1'b0;
            collision <= 1'b0;
            fbyte_q   <= 1'b0;
            fsx_q     <= 1'b0;
            fsel_q    <= '0;
        end else begin
            ready     <= fire;
            collision <= (|a_we) && write_enable_2 && (addr_q == addr2[DEPTH_LOG2-1:0]);
            if (a_re) begin
                fbyte_q <= be_q;
                fsx_q   <= sx_q;
                fsel_q  <= sel_q;
            end
        end
    end

    // An out-of-range lane matches nothing, so the byte read comes back as zero.
    always_comb begin
        lane = '0;
        for (int l = 0; l < LANES; l++) begin
            if (int'(fsel_q) == l) lane = a_rdata[8*l +: 8];
        end
        data_out = a_rdata;
        if (fbyte_q) begin
            data_out = DATA_W'(lane);
            if (fsx_q && lane[7]) data_out = data_out | ~LOW_MASK;
        end
    end

endmodule

// File: tb/tb_mem_ws_ctrl.sv
// Directed bench for mem_ws_ctrl: a WAIT_STATES=3 instance for the main vectors and
// a WAIT_STATES=7 instance for the reset-abort sequence.
module tb_mem_ws_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        en, write_enable, byte_enable, sign_ext, write_enable_2;
    logic [0:0]  byte_select;
    logic [15:0] addr, data_in, addr2, data_in2;

    logic [15:0] dout_a, dout2_a, dout_b, dout2_b;
    logic        wait_a, ready_a, coll_a, wait_b, ready_b, coll_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int lat;
    int ready_hits;

    typedef struct {
        logic        we;
        logic        be;
        logic [0:0]  sel;
        logic        sx;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    mem_ws_ctrl #(.LANES(2), .DEPTH_LOG2(14), .WAIT_STATES(3)) u_dut (
        .clk(clk), .rst(rst_a), .en(en), .write_enable(write_enable),
        .byte_enable(byte_enable), .byte_select(byte_select), .sign_ext(sign_ext),
        .addr(addr), .data_in(data_in), .data_out(dout_a), .mem_wait(wait_a),
        .ready(ready_a), .write_enable_2(write_enable_2), .addr2(addr2),
        .data_in2(data_in2), .data_out2(dout2_a), .collision(coll_a)
    );

    mem_ws_ctrl #(.LANES(2), .DEPTH_LOG2(14), .WAIT_STATES(7)) u_dut7 (
        .clk(clk), .rst(rst_b), .en(en), .write_enable(write_enable),
        .byte_enable(byte_enable), .byte_select(byte_select), .sign_ext(sign_ext),
        .addr(addr), .data_in(data_in), .data_out(dout_b), .mem_wait(wait_b),
        .ready(ready_b), .write_enable_2(write_enable_2), .addr2(addr2),
        .data_in2(data_in2), .data_out2(dout2_b), .collision(coll_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // One port-A access; starts just after a negedge and ends just after a negedge.
    task automatic access(input bit d7, input logic we, input logic be, input logic [0:0] sel,
                          input logic sx, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp, input string nm);
        int n, waits, ws;
        logic rdy, mw;
        ws = d7 ? 7 : 3;
        write_enable = we; byte_enable = be; byte_select = sel;
        sign_ext = sx; addr = a; data_in = d; en = 1'b1;
        #1;
        waits = (d7 ? wait_b : wait_a) ? 1 : 0;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 40) begin
            @(negedge clk);
            n++;
            rdy = d7 ? ready_b : ready_a;
            mw  = d7 ? wait_b : wait_a;
            if (mw) waits++;
            if (n == 1) begin
                en = 1'b0;
                write_enable = ~we; byte_enable = ~be; byte_select = ~sel;
                sign_ext = ~sx; addr = ~a; data_in = ~d;
            end
        end
        check({nm, "_latency"}, n, ws + 2);
        check({nm, "_wait_cycles"}, waits, ws + 2);
        check({nm, "_data_out"}, 32'(d7 ? dout_b : dout_a), 32'(exp));
        @(negedge clk);
        check({nm, "_ready_pulse"}, 32'(d7 ? ready_b : ready_a), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h1234, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h80FF, 16'h1234};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h0000, 16'hFF80};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0080};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 16'hFFFF};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h00FF};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h1234, 16'h00FF};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h00AB, 16'h00FF};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'hAB34};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hC031, 16'hBEEF, 16'hAB34};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0031, 16'h0000, 16'hBEEF};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0031, 16'h0000, 16'h00EF};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0031, 16'hFF7F, 16'h00EF};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h4031, 16'h0000, 16'hBE7F};

        rst_a = 1'b0; rst_b = 1'b0;
        en = 1'b0; write_enable = 1'b0; byte_enable = 1'b0; byte_select = 1'b0;
        sign_ext = 1'b0; addr = '0; data_in = '0;
        write_enable_2 = 1'b0; addr2 = '0; data_in2 = '0;

        #2;
        check("rst_data_out", 32'(dout_a), 32'h0);
        check("rst_data_out2", 32'(dout2_a), 32'h0);
        check("rst_ready", 32'(ready_a), 32'h0);
        check("rst_collision", 32'(coll_a), 32'h0);
        check("rst_wait_en0", 32'(wait_a), 32'h0);
        en = 1'b1; #1;
        check("rst_wait_en1", 32'(wait_a), 32'h1);
        en = 1'b0;

        @(negedge clk); rst_a = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            access(1'b0, tbl[i].we, tbl[i].be, tbl[i].sel, tbl[i].sx,
                   tbl[i].a, tbl[i].d, tbl[i].exp, $sformatf("vec%0d", i));
        end

        addr2 = 16'h0030; @(negedge clk);
        check("portb_read_0030", 32'(dout2_a), 32'hAB34);
        addr2 = 16'h8031; @(negedge clk);
        check("portb_read_0031_hi", 32'(dout2_a), 32'hBE7F);

        // Back-to-back: en held high across two requests.
        write_enable = 1'b1; byte_enable = 1'b0; byte_select = 1'b0; sign_ext = 1'b0;
        addr = 16'h0060; data_in = 16'h5A5A; en = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ready_a && lat < 40);
        check("b2b_first_latency", lat, 5);
        check("b2b_wait_at_handoff", 32'(wait_a), 32'h1);
        write_enable = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ready_a && lat < 40);
        en = 1'b0;
        check("b2b_second_latency", lat, 5);
        check("b2b_read_data", 32'(dout_a), 32'h5A5A);
        @(negedge clk);

        // Same-cycle dual write: port A lane 0, port B full word.
        write_enable_2 = 1'b1; addr2 = 16'h0040; data_in2 = 16'h7777;
        @(negedge clk); write_enable_2 = 1'b0;
        write_enable = 1'b1; byte_enable = 1'b1; byte_select = 1'b0;
        addr = 16'h0040; data_in = 16'h0011; en = 1'b1;
        @(negedge clk); en = 1'b0;
        repeat (3) @(negedge clk);
        check("coll_before", 32'(coll_a), 32'h0);
        write_enable_2 = 1'b1; addr2 = 16'h0040; data_in2 = 16'hAAAA;
        @(negedge clk);
        check("coll_ready", 32'(ready_a), 32'h1);
        check("coll_pulse", 32'(coll_a), 32'h1);
        check("coll_portb_rbw", 32'(dout2_a), 32'h7777);
        write_enable_2 = 1'b0;
        @(negedge clk);
        check("coll_after", 32'(coll_a), 32'h0);
        check("coll_merged_word", 32'(dout2_a), 32'hAA11);

        // Port-A read racing a port-B write to the same word sees the old word.
        write_enable = 1'b0; byte_enable = 1'b0; addr = 16'h0040; en = 1'b1;
        @(negedge clk); en = 1'b0;
        repeat (3) @(negedge clk);
        write_enable_2 = 1'b1; addr2 = 16'h0040; data_in2 = 16'h1111;
        @(negedge clk);
        check("rbw_porta_ready", 32'(ready_a), 32'h1);
        check("rbw_porta_data", 32'(dout_a), 32'hAA11);
        check("rbw_read_no_coll", 32'(coll_a), 32'h0);
        write_enable_2 = 1'b0;
        @(negedge clk);
        check("rbw_portb_new", 32'(dout2_a), 32'h1111);

        // WAIT_STATES=7 instance: reset in the middle of a write.
        rst_a = 1'b0; rst_b = 1'b1;
        write_enable_2 = 1'b1; addr2 = 16'h0051; data_in2 = 16'hCAFE;
        @(negedge clk);
        addr2 = 16'h0050; data_in2 = 16'h0000;
        @(negedge clk);
        write_enable_2 = 1'b0; addr2 = 16'h0051;
        @(negedge clk);
        access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0051, 16'h0000, 16'hCAFE, "w7_read");
        check("w7_portb_pre", 32'(dout2_b), 32'hCAFE);

        write_enable = 1'b1; byte_enable = 1'b0; addr = 16'h0050; data_in = 16'h5555; en = 1'b1;
        @(negedge clk); en = 1'b0;
        @(negedge clk);
        check("w7_busy_wait", 32'(wait_b), 32'h1);
        #2; rst_b = 1'b0; #1;
        check("abort_data_out", 32'(dout_b), 32'h0);
        check("abort_data_out2", 32'(dout2_b), 32'h0);
        check("abort_ready", 32'(ready_b), 32'h0);
        check("abort_collision", 32'(coll_b), 32'h0);
        check("abort_wait_en0", 32'(wait_b), 32'h0);
        en = 1'b1; #1;
        check("abort_wait_en1", 32'(wait_b), 32'h1);
        en = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_b = 1'b1;
        ready_hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (ready_b) ready_hits++;
        end
        check("abort_no_ready", ready_hits, 0);
        addr2 = 16'h0050; @(negedge clk);
        check("abort_portb_word", 32'(dout2_b), 32'h0000);
        access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0000, "w7_after_abort");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
